// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM Avalon-MM responder.
//   SRAM_ADDR_W / SRAM_DATA_W : widths of the board SRAM address and data pins
//   SRAM_CNT_W                : width of the wait-state down-counter (0..15 extra cycles)
//   sram_state_e              : responder FSM state encoding
package sram_pkg;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 16;
   localparam int SRAM_CNT_W  = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      WR     = 3'd2,
      DONE_R = 3'd3,
      DONE_W = 3'd4
   } sram_state_e;

endpackage

// File: rtl/sram_dq_iobuf.sv
// Tri-state buffer for the bidirectional SRAM data bus.
//   drive_en : 1 drives dout onto dq, 0 leaves dq hi-Z
//   dout     : data to drive during writes
//   din      : current value seen on the pins
//   dq       : SRAM_DQ pad connection
module sram_dq_iobuf
   import sram_pkg::*;
#(
   parameter int DATA_W = SRAM_DATA_W
) (
   input  logic              drive_en,
   input  logic [DATA_W-1:0] dout,
   output logic [DATA_W-1:0] din,
   inout  wire  [DATA_W-1:0] dq
);

   assign dq  = drive_en ? dout : {DATA_W{1'bz}};
   assign din = dq;

endmodule

// File: rtl/sram_avalon_responder.sv
// Avalon-MM slave driving a 16-bit asynchronous SRAM with a fixed number of
// wait states. Every SRAM pin output is registered.
//   clk_0, reset        : clock and synchronous active-high reset
//   avs_*               : Avalon-MM slave port (word address, byte enables,
//                         waitrequest low for the single completion cycle)
//   SRAM_*              : SRAM pads (all control signals active low)
//
// state  | meaning
// IDLE   | bus turnaround, sample command
// RD     | OE_N low, counting read wait states
// WR     | WE_N low, counting write wait states
// DONE_R | read completion cycle, readdata valid
// DONE_W | write completion cycle, address/data/masks held
module sram_avalon_responder
   import sram_pkg::*;
#(
   parameter int ADDR_W     = SRAM_ADDR_W,
   parameter int DATA_W     = SRAM_DATA_W,
   parameter int READ_WAIT  = 1,
   parameter int WRITE_WAIT = 1
) (
   input  logic              clk_0,
   input  logic              reset,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [1:0]        avs_byteenable,
   input  logic [DATA_W-1:0] avs_writedata,
   output logic [DATA_W-1:0] avs_readdata,
   output logic              avs_waitrequest,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N
);

   localparam logic [SRAM_CNT_W-1:0] RD_CNT_INIT = SRAM_CNT_W'(READ_WAIT);
   localparam logic [SRAM_CNT_W-1:0] WR_CNT_INIT = SRAM_CNT_W'(WRITE_WAIT);

   sram_state_e           state;
   logic [SRAM_CNT_W-1:0] wait_cnt;
   logic                  dq_drive_en;
   logic [DATA_W-1:0]     dq_out;
   logic [DATA_W-1:0]     dq_in;

   sram_dq_iobuf #(
      .DATA_W (DATA_W)
   ) u_dq (
      .drive_en (dq_drive_en),
      .dout     (dq_out),
      .din      (dq_in),
      .dq       (SRAM_DQ)
   );

   always_ff @(posedge clk_0) begin
      if (reset) begin
         state           <= IDLE;
         wait_cnt        <= '0;
         avs_waitrequest <= 1'b1;
         avs_readdata    <= '0;
         SRAM_ADDR       <= '0;
         SRAM_CE_N       <= 1'b1;
         SRAM_OE_N       <= 1'b1;
         SRAM_WE_N       <= 1'b1;
         SRAM_UB_N       <= 1'b1;
         SRAM_LB_N       <= 1'b1;
         dq_drive_en     <= 1'b0;
         dq_out          <= '0;
      end else begin
         // waitrequest is only dropped on the transition into a DONE state
         avs_waitrequest <= 1'b1;
         case (state)
            IDLE: begin
               // write wins over a simultaneous read; the read is dropped
               if (avs_write) begin
                  if (avs_byteenable == 2'b00) begin
                     state           <= DONE_W;
                     avs_waitrequest <= 1'b0;
                  end else begin
                     state       <= WR;
                     SRAM_ADDR   <= avs_address;
                     dq_out      <= avs_writedata;
                     dq_drive_en <= 1'b1;
                     SRAM_UB_N   <= ~avs_byteenable[1];
                     SRAM_LB_N   <= ~avs_byteenable[0];
                     SRAM_CE_N   <= 1'b0;
                     SRAM_WE_N   <= 1'b0;
                     wait_cnt    <= WR_CNT_INIT;
                  end
               end else if (avs_read) begin
                  state     <= RD;
                  SRAM_ADDR <= avs_address;
                  SRAM_UB_N <= 1'b0;
                  SRAM_LB_N <= 1'b0;
                  SRAM_CE_N <= 1'b0;
                  SRAM_OE_N <= 1'b0;
                  wait_cnt  <= RD_CNT_INIT;
               end
            end
            RD: begin
               if (wait_cnt == '0) begin
                  avs_readdata    <= dq_in;
                  SRAM_OE_N       <= 1'b1;
                  state           <= DONE_R;
                  avs_waitrequest <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            WR: begin
               // address, data and masks stay put through DONE_W for hold time
               if (wait_cnt == '0) begin
                  SRAM_WE_N       <= 1'b1;
                  state           <= DONE_W;
                  avs_waitrequest <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            DONE_R, DONE_W: begin
               SRAM_CE_N   <= 1'b1;
               SRAM_UB_N   <= 1'b1;
               SRAM_LB_N   <= 1'b1;
               dq_drive_en <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sram_avalon_responder.md
Name: sram_avalon_responder

Overview:
Avalon-MM slave that answers word reads and writes from the Nios II processor and drives the board's 16-bit asynchronous SRAM (SRAM_* pins).
It sits between the system interconnect and the top-level SRAM pads. It replaces the generated sram_0 peripheral with a parameterised, cycle-exact controller that uses a fixed number of wait states.
Every SRAM pin output is registered, so the pad timing is identical on every access.

Parameters:
ADDR_W, 20, word address width (matches SRAM_ADDR)
DATA_W, 16, data width (matches SRAM_DQ)
READ_WAIT, 1, extra cycles OE_N is held low beyond the first (0..15)
WRITE_WAIT, 1, extra cycles WE_N is held low beyond the first (0..15)

Ports:
clk_0  in  1  system clock, 50 MHz; all logic on the rising edge
reset  in  1  synchronous, active-high reset
avs_address  in  ADDR_W  word address
avs_read  in  1  read request; held by the master while avs_waitrequest=1
avs_write  in  1  write request; held by the master while avs_waitrequest=1
avs_byteenable  in  2  bit1 = upper byte, bit0 = lower byte
avs_writedata  in  DATA_W  write data
avs_readdata  out  DATA_W  read data; valid in the cycle avs_waitrequest=0 for a read
avs_waitrequest  out  1  low for exactly the one completion cycle of each transfer
SRAM_DQ  inout  DATA_W  SRAM data bus; tri-stated except during writes
SRAM_ADDR  out  ADDR_W  SRAM address
SRAM_UB_N  out  1  upper-byte mask, active low
SRAM_LB_N  out  1  lower-byte mask, active low
SRAM_WE_N  out  1  write enable, active low
SRAM_CE_N  out  1  chip enable, active low
SRAM_OE_N  out  1  output enable, active low

Behaviour:
- Reset values:
  - avs_waitrequest=1, avs_readdata=0.
  - SRAM_ADDR=0, SRAM_CE_N=1, SRAM_OE_N=1, SRAM_WE_N=1, SRAM_UB_N=1, SRAM_LB_N=1.
  - DQ output enable=0 (bus hi-Z).
  - FSM in IDLE, wait counter=0.
- FSM states: IDLE, RD, WR, DONE_R, DONE_W.
- IDLE:
  - avs_waitrequest=1.
  - Command sampled each cycle; write has priority when avs_read and avs_write are both high (the read is ignored, not queued).
  - write with byteenable=00 → DONE_W directly, no WE pulse.
  - write otherwise → WR. Registers ADDR, writedata onto DQ (drive enabled), UB_N=~be[1], LB_N=~be[0], CE_N=0, WE_N=0. Counter=WRITE_WAIT.
  - read → RD. Registers ADDR, CE_N=0, OE_N=0, UB_N=LB_N=0 (reads always return the full word; the master ignores disabled bytes). Counter=READ_WAIT.
- RD:
  - Counter decrements each cycle.
  - At count 0: capture SRAM_DQ into avs_readdata, set OE_N=1, go to DONE_R.
  - OE_N is low for exactly READ_WAIT+1 cycles.
- WR:
  - Counter decrements each cycle.
  - At count 0: set WE_N=1, go to DONE_W. ADDR, DQ and masks are held through DONE_W (hold time).
  - WE_N is low for exactly WRITE_WAIT+1 cycles.
- DONE_R / DONE_W:
  - avs_waitrequest=0 for one cycle; readdata stays stable.
  - Next edge: CE_N=1, UB_N=LB_N=1, DQ drive released, go to IDLE.
- Latency: command first presented in cycle n; completion (waitrequest=0) in cycle n+READ_WAIT+2 or n+WRITE_WAIT+2. Byteenable-00 write completes at n+1.
- Throughput: minimum WAIT+3 cycles per transfer. The IDLE cycle is the bus turnaround, so DQ drive and OE_N low never overlap.
- avs_readdata holds the last read value until the next read completes; writes do not change it.
- Command signals are ignored outside IDLE. A master changing them mid-transfer is a protocol violation; the transfer in progress continues with its latched address and data.
- Address wrap: none. ADDR_W bits are passed through unchanged.
- Reset mid-operation: the next edge forces all reset values. WE_N/OE_N return high and DQ goes hi-Z in the same edge. The aborted transfer never completes (no waitrequest=0 pulse).

Decomposition:
- Shared package sram_pkg:
  - FSM state enum.
  - Constants SRAM_ADDR_W=20, SRAM_DATA_W=16.
  - Counter width, 4 bits.
- One sub-module: sram_dq_iobuf, the tri-state buffer (drive enable, output data, input data). It keeps the inout in one place for synthesis and for the bench model.
- No further hierarchy.

Test Plan:
All scenarios use defaults READ_WAIT=1, WRITE_WAIT=1 and a behavioural SRAM model on the pins.
- Full write: write addr=0x00012, data=0xBEEF, be=11, command at cycle n.
  - WE_N=0 in cycles n+1 and n+2; UB_N=LB_N=0; DQ=0xBEEF in n+1..n+3.
  - waitrequest=0 only in n+3; CE_N=1 at n+4; model holds 0xBEEF.
- Read back: read addr=0x00012 at cycle m.
  - OE_N=0 in m+1 and m+2; readdata=0xBEEF with waitrequest=0 in m+3.
  - DQ never driven by the DUT in m..m+4.
- Byte write then read: write 0x12AB be=01 to 0x00012, then read.
  - LB_N=0, UB_N=1 during the write; readdata=0xBEAB.
- Simultaneous read and write, plus zero-byte write:
  - read=write=1, addr=0xFFFFF, data=0x5A5A → a write occurs; a later read returns 0x5A5A.
  - write be=00 → waitrequest=0 at n+1, WE_N never low.
- Reset mid-read: assert reset in cycle m+1 of a read.
  - Next edge gives OE_N=1, CE_N=1, waitrequest=1, readdata=0, DQ hi-Z; no completion pulse.
  - A following write/read pair succeeds.
